bandai_unlock_rx: RTL and testbench

- Console-side initiator and receiver for the cartridge mapper unlock handshake.
- On command, it presents the unlock-request address on the cartridge address bus for one cycle, then captures the serial frame the mapper returns on its synchronous-out line.
- It checks the frame and, on a match, asserts UNLOCKED, which is bit 7 of SYSTEM_CTRL1 (A0h) in the console register file.
- Sits between the console bus controller and the cartridge connector, in the same clock domain as the cartridge CLK.

---
 rtl/bandai_unlock_rx.sv | 174 +++++++++++++++++
 tb/tb_bandai_unlock_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bandai_unlock_rx.sv
// Console-side initiator/receiver for the cartridge mapper unlock handshake.
// Optional retry on failure is compiled in with `define BANDAI_UNLOCK_RETRY_EN.
module bandai_unlock_rx #(
  parameter logic [7:0]  REQ_ADDR  = 8'hA5,
  parameter logic [7:0]  IDLE_ADDR = 8'h00,
  parameter logic [15:0] EXP_WORD  = 16'h28A0,
  parameter int unsigned TIMEOUT   = 32,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        START,
  input  logic        SI,
  output logic [7:0]  ADDR,
  output logic        BUSY,
  output logic        UNLOCKED,
  output logic        FAIL,
  output logic [15:0] RXWORD
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitStart,
    StShift,
    StStop,
    StDone,
    StFailChk,
    StFail
  } state_e;

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);
  localparam logic [3:0] BitLast = 4'd15;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic        unlocked_q, unlocked_d;
  logic        fail_q, fail_d;
  logic [15:0] rxword_q, rxword_d;
  logic [15:0] shreg_q, shreg_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [3:0]  bit_q, bit_d;

`ifdef BANDAI_UNLOCK_RETRY_EN
  localparam logic [7:0] RetryMax = 8'(MAX_RETRY);
  logic [7:0] retry_q, retry_d;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      retry_q <= 8'd0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= StIdle;
      addr_q     <= IDLE_ADDR;
      unlocked_q <= 1'b0;
      fail_q     <= 1'b0;
      rxword_q   <= 16'h0000;
      shreg_q    <= 16'h0000;
      tmo_q      <= 8'd0;
      bit_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      unlocked_q <= unlocked_d;
      fail_q     <= fail_d;
      rxword_q   <= rxword_d;
      shreg_q    <= shreg_d;
      tmo_q      <= tmo_d;
      bit_q      <= bit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    unlocked_d = unlocked_q;
    fail_d     = fail_q;
    rxword_d   = rxword_q;
    shreg_d    = shreg_q;
    tmo_d      = tmo_q;
    bit_d      = bit_q;
`ifdef BANDAI_UNLOCK_RETRY_EN
    retry_d    = retry_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d    = StReq;
          unlocked_d = 1'b0;
          fail_d     = 1'b0;
`ifdef BANDAI_UNLOCK_RETRY_EN
          retry_d    = 8'd0;
`endif
        end
      end
      // The mapper loads its shift register on this edge; start bit follows next cycle.
      StReq: begin
        state_d = StWaitStart;
        tmo_d   = 8'd0;
      end
      StWaitStart: begin
        if (!SI) begin
          state_d = StShift;
          bit_d   = 4'd0;
        end else if (tmo_q == TmoLast) begin
          state_d = StFailChk;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      // LSB arrives first, so shifting right from bit 15 leaves it in bit 0.
      StShift: begin
        shreg_d = {SI, shreg_q[15:1]};
        if (bit_q == BitLast) begin
          state_d = StStop;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      StStop: begin
        rxword_d = shreg_q;
        if (!SI && (shreg_q == EXP_WORD)) begin
          state_d = StDone;
        end else begin
          state_d = StFailChk;
        end
      end
      StDone: begin
        unlocked_d = 1'b1;
      end
      StFailChk: begin
`ifdef BANDAI_UNLOCK_RETRY_EN
        if (retry_q < RetryMax) begin
          state_d = StReq;
          retry_d = retry_q + 8'd1;
        end else begin
          state_d = StFail;
          fail_d  = 1'b1;
        end
`else
        state_d = StFail;
        fail_d  = 1'b1;
`endif
      end
      StFail: begin
        if (START) begin
          state_d = StReq;
          fail_d  = 1'b0;
`ifdef BANDAI_UNLOCK_RETRY_EN
          retry_d = 8'd0;
`endif
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    addr_d = (state_d == StReq) ? REQ_ADDR : IDLE_ADDR;
  end

  assign ADDR     = addr_q;
  assign BUSY     = (state_q != StIdle) && (state_q != StDone) && (state_q != StFail);
  assign UNLOCKED = unlocked_q;
  assign FAIL     = fail_q;
  assign RXWORD   = rxword_q;

endmodule

// File: tb/tb_bandai_unlock_rx.sv
// Self-checking bench for bandai_unlock_rx (default build, no retry).
module tb_bandai_unlock_rx;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b1;
  logic        START = 1'b0;
  logic        SI = 1'b1;
  logic [7:0]  ADDR;
  logic        BUSY;
  logic        UNLOCKED;
  logic        FAIL;
  logic [15:0] RXWORD;

  int n_cmp = 0;
  int n_err = 0;

  bandai_unlock_rx dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .START    (START),
    .SI       (SI),
    .ADDR     (ADDR),
    .BUSY     (BUSY),
    .UNLOCKED (UNLOCKED),
    .FAIL     (FAIL),
    .RXWORD   (RXWORD)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [15:0] word;
    logic        stop;
    int          delay;       // extra idle-high cycles before the start bit
    int          extra_start; // cycle after START at which to pulse START again (0 = none)
    logic [15:0] exp_rx;
    logic        exp_unl;
    logic        exp_fail;
    int          exp_lat;
    int          exp_a5;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] rx;
    logic        unl;
    logic        fail;
    int          lat;
    int          a5;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input bit chk);
    RSTn  = 1'b0;
    START = 1'b0;
    SI    = 1'b1;
    #2;
    if (chk) begin
      check("reset_addr", 32'(ADDR), 32'h00);
      check("reset_busy", 32'(BUSY), 32'h0);
      check("reset_unlocked", 32'(UNLOCKED), 32'h0);
      check("reset_fail", 32'(FAIL), 32'h0);
      check("reset_rxword", 32'(RXWORD), 32'h0);
    end
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
  endtask

  task automatic run_frame(input vec_t v);
    exp_t        e;
    exp_t        cur;
    logic [17:0] frame;
    int          a5;
    int          lat;
    int          idx;
    bit          popped;
    frame  = {v.stop, v.word, 1'b0};
    e      = '{v.name, v.exp_rx, v.exp_unl, v.exp_fail, v.exp_lat, v.exp_a5};
    sb.push_back(e);
    popped = 1'b0;
    START  = 1'b1;
    SI     = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    check({v.name, "_busy_after_start"}, 32'(BUSY), 32'h1);
    a5  = (ADDR == 8'hA5) ? 1 : 0;
    lat = -1;
    for (int n = 1; n <= 90; n++) begin
      @(posedge CLK);
      #1;
      if (ADDR == 8'hA5) a5++;
      if (lat < 0 && (UNLOCKED || FAIL)) begin
        lat    = n;
        cur    = sb.pop_front();
        popped = 1'b1;
        check({cur.name, "_latency"}, 32'(lat), 32'(cur.lat));
        check({cur.name, "_unlocked"}, 32'(UNLOCKED), 32'(cur.unl));
        check({cur.name, "_fail"}, 32'(FAIL), 32'(cur.fail));
        check({cur.name, "_rxword"}, 32'(RXWORD), 32'(cur.rx));
      end
      idx   = n - 1 - v.delay;
      SI    = (idx >= 0 && idx < 18) ? frame[idx] : 1'b1;
      START = (n == v.extra_start);
      if (lat >= 0 && n >= lat + 3) break;
    end
    START = 1'b0;
    SI    = 1'b1;
    if (!popped) begin
      cur = sb.pop_front();
      check({cur.name, "_no_flag_within_bound"}, 32'hFFFF_FFFF, 32'(cur.lat));
    end
    check({cur.name, "_a5_cycles"}, 32'(a5), 32'(cur.a5));
    check({cur.name, "_busy_end"}, 32'(BUSY), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] fr;
    int          a5;
    fr = {1'b0, 16'h28A0, 1'b0};

    tbl[0] = '{"nominal",      16'h28A0, 1'b0, 0,  0, 16'h28A0, 1'b1, 1'b0, 20, 1};
    tbl[1] = '{"wrong_word",   16'h28A1, 1'b0, 0,  0, 16'h28A1, 1'b0, 1'b1, 20, 1};
    tbl[2] = '{"bad_stop",     16'h28A0, 1'b1, 0,  0, 16'h28A0, 1'b0, 1'b1, 20, 1};
    tbl[3] = '{"silent",       16'h28A0, 1'b0, 99, 0, 16'h0000, 1'b0, 1'b1, 34, 1};
    tbl[4] = '{"late5",        16'h28A0, 1'b0, 5,  0, 16'h28A0, 1'b1, 1'b0, 25, 1};
    tbl[5] = '{"late31",       16'h28A0, 1'b0, 31, 0, 16'h28A0, 1'b1, 1'b0, 51, 1};
    tbl[6] = '{"late32",       16'h28A0, 1'b0, 32, 0, 16'h0000, 1'b0, 1'b1, 34, 1};
    tbl[7] = '{"start_in_shift", 16'h28A0, 1'b0, 0, 8, 16'h28A0, 1'b1, 1'b0, 20, 1};
    tbl[8] = '{"all_ones",     16'hFFFF, 1'b0, 0,  0, 16'hFFFF, 1'b0, 1'b1, 20, 1};
    tbl[9] = '{"bit_reversed", 16'h0514, 1'b0, 0,  0, 16'h0514, 1'b0, 1'b1, 20, 1};

    for (int i = 0; i < 10; i++) begin
      do_reset(i == 0);
      run_frame(tbl[i]);
    end

    // Restart from FAIL, then reset asynchronously after the 8th payload bit.
    do_reset(1'b0);
    run_frame(tbl[1]);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    check("restart_fail_cleared", 32'(FAIL), 32'h0);
    check("restart_addr_req", 32'(ADDR), 32'hA5);
    check("restart_busy", 32'(BUSY), 32'h1);
    for (int n = 1; n <= 10; n++) begin
      @(posedge CLK);
      #1;
      SI = fr[n-1];
    end
    #1;
    RSTn = 1'b0;
    #1;
    check("midreset_addr", 32'(ADDR), 32'h00);
    check("midreset_busy", 32'(BUSY), 32'h0);
    check("midreset_unlocked", 32'(UNLOCKED), 32'h0);
    check("midreset_fail", 32'(FAIL), 32'h0);
    check("midreset_rxword", 32'(RXWORD), 32'h0);
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    SI   = 1'b1;
    run_frame(tbl[0]);

    // START while unlocked must not issue another request.
    START = 1'b1;
    a5    = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge CLK);
      #1;
      START = 1'b0;
      if (ADDR == 8'hA5) a5++;
    end
    check("done_start_a5_cycles", 32'(a5), 32'h0);
    check("done_sticky_unlocked", 32'(UNLOCKED), 32'h1);
    check("done_busy", 32'(BUSY), 32'h0);
    check("done_fail", 32'(FAIL), 32'h0);
    check("done_rxword", 32'(RXWORD), 32'h28A0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
